// File: rtl/axi_read_arbiter.sv
// Round-robin read arbiter: grants M0 or M1, forwards AR, steers R back to the owner.
// Latency: AR appears on the decoder side 1 cycle after request; R paths are combinational.
// Backpressure: ARREADY_S/RREADY_Mx pass straight through to the owner; losers wait.
module axi_read_arbiter #(
    parameter int ID_BITS   = 4,
    parameter int MID_BITS  = 4,
    parameter int ADDR_BITS = 32,
    parameter int LEN_BITS  = 4
) (
    input  logic                         ACLK,
    input  logic                         ARESETn,
    input  logic [ID_BITS-1:0]           ARID_M0,
    input  logic [ID_BITS-1:0]           ARID_M1,
    input  logic [ADDR_BITS-1:0]         ARADDR_M0,
    input  logic [ADDR_BITS-1:0]         ARADDR_M1,
    input  logic [LEN_BITS-1:0]          ARLEN_M0,
    input  logic [LEN_BITS-1:0]          ARLEN_M1,
    input  logic [2:0]                   ARSIZE_M0,
    input  logic [2:0]                   ARSIZE_M1,
    input  logic [1:0]                   ARBURST_M0,
    input  logic [1:0]                   ARBURST_M1,
    input  logic                         ARVALID_M0,
    input  logic                         ARVALID_M1,
    output logic                         ARREADY_M0,
    output logic                         ARREADY_M1,
    output logic [ID_BITS+MID_BITS-1:0]  ARID_S,
    output logic [ADDR_BITS-1:0]         ARADDR_S,
    output logic [LEN_BITS-1:0]          ARLEN_S,
    output logic [2:0]                   ARSIZE_S,
    output logic [1:0]                   ARBURST_S,
    output logic                         ARVALID_S,
    input  logic                         ARREADY_S,
    input  logic                         RVALID_S,
    input  logic                         RLAST_S,
    output logic                         RREADY_S,
    output logic                         RVALID_M0,
    output logic                         RVALID_M1,
    input  logic                         RREADY_M0,
    input  logic                         RREADY_M1,
    output logic                         OWNER,
    output logic                         LEN_ERR
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    localparam logic [LEN_BITS:0] CNT_MAX = {1'b1, {LEN_BITS{1'b0}}};

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                owner_q, owner_d;
    logic [LEN_BITS:0]   beat_cnt_q, beat_cnt_d;
    logic [LEN_BITS-1:0] len_q, len_d;
    logic                len_err_q, len_err_d;
    logic                over_q, over_d;

    logic                 g_arvalid;
    logic                 g_rready;
    logic [ID_BITS-1:0]   g_arid;
    logic [ADDR_BITS-1:0] g_araddr;
    logic [LEN_BITS-1:0]  g_arlen;
    logic [2:0]           g_arsize;
    logic [1:0]           g_arburst;
    logic [MID_BITS-1:0]  mid;
    logic                 r_hs;

    assign g_arvalid = owner_q ? ARVALID_M1 : ARVALID_M0;
    assign g_rready  = owner_q ? RREADY_M1  : RREADY_M0;
    assign g_arid    = owner_q ? ARID_M1    : ARID_M0;
    assign g_araddr  = owner_q ? ARADDR_M1  : ARADDR_M0;
    assign g_arlen   = owner_q ? ARLEN_M1   : ARLEN_M0;
    assign g_arsize  = owner_q ? ARSIZE_M1  : ARSIZE_M0;
    assign g_arburst = owner_q ? ARBURST_M1 : ARBURST_M0;
    assign mid       = {{(MID_BITS-1){1'b0}}, owner_q};
    assign r_hs      = RVALID_S & g_rready;

    assign OWNER   = owner_q;
    assign LEN_ERR = len_err_q;

    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        len_d      = len_q;
        len_err_d  = 1'b0;
        over_d     = over_q;
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARID_S     = '0;
        ARADDR_S   = '0;
        ARLEN_S    = '0;
        ARSIZE_S   = '0;
        ARBURST_S  = '0;
        ARVALID_S  = 1'b0;
        RREADY_S   = 1'b0;
        RVALID_M0  = 1'b0;
        RVALID_M1  = 1'b0;

        case (state_q)
            IDLE: begin
                if (ARVALID_M0 | ARVALID_M1) begin
                    owner_d = (ARVALID_M0 & ARVALID_M1) ? prio_q : ARVALID_M1;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S  = g_arvalid;
                ARID_S     = {mid, g_arid};
                ARADDR_S   = g_araddr;
                ARLEN_S    = g_arlen;
                ARSIZE_S   = g_arsize;
                ARBURST_S  = g_arburst;
                ARREADY_M0 = ~owner_q & ARREADY_S;
                ARREADY_M1 = owner_q & ARREADY_S;
                if (g_arvalid & ARREADY_S) begin
                    len_d      = g_arlen;
                    beat_cnt_d = '0;
                    over_d     = 1'b0;
                    state_d    = DATA;
                end
            end
            DATA: begin
                RVALID_M0 = ~owner_q & RVALID_S;
                RVALID_M1 = owner_q & RVALID_S;
                RREADY_S  = g_rready;
                if (r_hs) begin
                    if (beat_cnt_q != CNT_MAX) beat_cnt_d = beat_cnt_q + (LEN_BITS+1)'(1);
                    // An overrun already reported is not reported a second time at RLAST.
                    if (RLAST_S) begin
                        state_d   = IDLE;
                        prio_d    = ~owner_q;
                        len_err_d = (beat_cnt_q != {1'b0, len_q}) & ~over_q;
                    end else if ((beat_cnt_q == {1'b0, len_q}) && !over_q) begin
                        len_err_d = 1'b1;
                        over_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q    <= IDLE;
            prio_q     <= 1'b0;
            owner_q    <= 1'b0;
            beat_cnt_q <= '0;
            len_q      <= '0;
            len_err_q  <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prio_q     <= prio_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
            len_q      <= len_d;
            len_err_q  <= len_err_d;
            over_q     <= over_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Bench for axi_read_arbiter: vector table of single transactions plus hand-built corner sequences.
module tb_axi_read_arbiter;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic [3:0]  ARID_M0 = '0, ARID_M1 = '0;
    logic [31:0] ARADDR_M0 = '0, ARADDR_M1 = '0;
    logic [3:0]  ARLEN_M0 = '0, ARLEN_M1 = '0;
    logic [2:0]  ARSIZE_M0 = '0, ARSIZE_M1 = '0;
    logic [1:0]  ARBURST_M0 = '0, ARBURST_M1 = '0;
    logic        ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
    logic        ARREADY_M0, ARREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S;
    logic        ARREADY_S = 1'b1;
    logic        RVALID_S = 1'b0, RLAST_S = 1'b0;
    logic        RREADY_S;
    logic        RVALID_M0, RVALID_M1;
    logic        RREADY_M0 = 1'b0, RREADY_M1 = 1'b0;
    logic        OWNER, LEN_ERR;

    always #5 ACLK = ~ACLK;

    axi_read_arbiter #(.ID_BITS(4), .MID_BITS(4), .ADDR_BITS(32), .LEN_BITS(4)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .ARID_M0(ARID_M0), .ARID_M1(ARID_M1),
        .ARADDR_M0(ARADDR_M0), .ARADDR_M1(ARADDR_M1),
        .ARLEN_M0(ARLEN_M0), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M0(ARSIZE_M0), .ARSIZE_M1(ARSIZE_M1),
        .ARBURST_M0(ARBURST_M0), .ARBURST_M1(ARBURST_M1),
        .ARVALID_M0(ARVALID_M0), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M0(ARREADY_M0), .ARREADY_M1(ARREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
        .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
        .RVALID_S(RVALID_S), .RLAST_S(RLAST_S), .RREADY_S(RREADY_S),
        .RVALID_M0(RVALID_M0), .RVALID_M1(RVALID_M1),
        .RREADY_M0(RREADY_M0), .RREADY_M1(RREADY_M1),
        .OWNER(OWNER), .LEN_ERR(LEN_ERR)
    );

    typedef struct {
        logic        m;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nbeats;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [7:0]  arid;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_exp_t;

    ar_exp_t exp_q[$];
    int checks = 0;
    int passes = 0;
    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Scoreboard: every AR handshake on the decoder side must match the oldest expectation.
    always @(negedge ACLK) begin
        ar_exp_t e;
        if (ARESETn && ARVALID_S && ARREADY_S) begin
            if (exp_q.size() == 0) begin
                chk("ar_unexpected", 64'(exp_q.size()), 1);
            end else begin
                e = exp_q.pop_front();
                chk("arid_s", ARID_S, e.arid);
                chk("araddr_s", ARADDR_S, e.addr);
                chk("arlen_s", ARLEN_S, e.len);
                chk("arsize_s", ARSIZE_S, e.size);
                chk("arburst_s", ARBURST_S, e.burst);
            end
        end
    end

    task automatic drive_ar(input vec_t v);
        ar_exp_t e;
        e.arid  = {4'(v.m), v.id};
        e.addr  = v.addr;
        e.len   = v.len;
        e.size  = v.size;
        e.burst = v.burst;
        if (v.m) begin
            ARID_M1 = v.id; ARADDR_M1 = v.addr; ARLEN_M1 = v.len;
            ARSIZE_M1 = v.size; ARBURST_M1 = v.burst; ARVALID_M1 = 1'b1;
        end else begin
            ARID_M0 = v.id; ARADDR_M0 = v.addr; ARLEN_M0 = v.len;
            ARSIZE_M0 = v.size; ARBURST_M0 = v.burst; ARVALID_M0 = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns just after the posedge that completes the AR handshake.
    task automatic ar_phase(input logic m);
        int n = 0;
        while (!(ARVALID_S && ARREADY_S) && n < 30) begin
            @(negedge ACLK);
            n++;
        end
        chk("ar_handshake_seen", ARVALID_S && ARREADY_S, 1);
        chk("arready_owner", m ? ARREADY_M1 : ARREADY_M0, 1);
        chk("arready_other", m ? ARREADY_M0 : ARREADY_M1, 0);
        chk("owner_at_grant", OWNER, m);
        @(posedge ACLK); #1;
        if (m) ARVALID_M1 = 1'b0; else ARVALID_M0 = 1'b0;
    endtask

    // Delivers nbeats R beats with a randomly stalling master; ends at a negedge.
    task automatic r_phase(input logic m, input int nbeats, input logic exp_err);
        for (int b = 0; b < nbeats; b++) begin
            logic hs;
            int   n;
            hs = 1'b0;
            n  = 0;
            RVALID_S = 1'b1;
            RLAST_S  = (b == nbeats - 1);
            while (!hs) begin
                hs = ($urandom_range(0, 2) != 0) || (n >= 4);
                if (m) RREADY_M1 = hs; else RREADY_M0 = hs;
                @(negedge ACLK);
                chk("rvalid_owner", m ? RVALID_M1 : RVALID_M0, 1);
                chk("rvalid_other", m ? RVALID_M0 : RVALID_M1, 0);
                chk("rready_s", RREADY_S, hs);
                chk("len_err_mid", LEN_ERR, 0);
                @(posedge ACLK); #1;
                n++;
            end
        end
        RVALID_S = 1'b0; RLAST_S = 1'b0; RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
        @(negedge ACLK);
        chk("len_err", LEN_ERR, exp_err);
        chk("idle_arvalid_s", ARVALID_S, 0);
        chk("owner_hold", OWNER, m);
        @(posedge ACLK); #1;
        @(negedge ACLK);
        chk("len_err_single_pulse", LEN_ERR, 0);
    endtask

    task automatic do_txn(input vec_t v);
        @(posedge ACLK); #1;
        drive_ar(v);
        @(negedge ACLK);
        chk("arb_latency", ARVALID_S, 0);
        ar_phase(v.m);
        r_phase(v.m, v.nbeats, v.exp_err);
    endtask

    task automatic both_request(input vec_t a0, input vec_t a1);
        @(posedge ACLK); #1;
        drive_ar(a0);
        drive_ar(a1);
        @(negedge ACLK);
        chk("both_arb_latency", ARVALID_S, 0);
        ar_phase(1'b0);
        r_phase(1'b0, a0.nbeats, a0.exp_err);
        ar_phase(1'b1);
        r_phase(1'b1, a1.nbeats, a1.exp_err);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t p0, p1, v5, v6;
        //          m     id     addr           len    size  burst nbeats err
        vecs[0] = '{1'b0, 4'h5, 32'h0000_0010, 4'd0,  3'd2, 2'd1, 1,  1'b0};
        vecs[1] = '{1'b1, 4'h3, 32'h0000_2000, 4'd3,  3'd2, 2'd1, 4,  1'b0};
        vecs[2] = '{1'b0, 4'hA, 32'h0000_0100, 4'd3,  3'd1, 2'd1, 2,  1'b1};
        vecs[3] = '{1'b1, 4'hF, 32'hFFFF_FFC0, 4'd15, 3'd3, 2'd2, 16, 1'b0};
        vecs[4] = '{1'b0, 4'h0, 32'h8000_0004, 4'd1,  3'd0, 2'd0, 1,  1'b1};
        p0 = '{1'b0, 4'h7, 32'h0000_0040, 4'd0, 3'd2, 2'd1, 1, 1'b0};
        p1 = '{1'b1, 4'h9, 32'h0000_0080, 4'd0, 3'd2, 2'd1, 1, 1'b0};
        v5 = '{1'b0, 4'hC, 32'h1234_5678, 4'd1, 3'd2, 2'd1, 2, 1'b0};
        v6 = '{1'b1, 4'h2, 32'h0000_3000, 4'd3, 3'd2, 2'd1, 4, 1'b0};

        // Reset state, with slave R activity that must not leak through.
        RVALID_S = 1'b1;
        #12;
        chk("rst_arvalid_s", ARVALID_S, 0);
        chk("rst_rvalid_m0", RVALID_M0, 0);
        chk("rst_rvalid_m1", RVALID_M1, 0);
        chk("rst_rready_s", RREADY_S, 0);
        chk("rst_arready_m0", ARREADY_M0, 0);
        chk("rst_owner", OWNER, 0);
        chk("rst_len_err", LEN_ERR, 0);
        RVALID_S = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Simultaneous requests after reset: M0 first, then M1.
        both_request(p0, p1);

        for (int i = 0; i < 5; i++) do_txn(vecs[i]);

        // Decoder stalls AR for 5 cycles: fields must hold, master sees no ready.
        @(posedge ACLK); #1;
        ARREADY_S = 1'b0;
        drive_ar(v5);
        @(negedge ACLK);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            chk("stall_arvalid_s", ARVALID_S, 1);
            chk("stall_araddr_s", ARADDR_S, v5.addr);
            chk("stall_arid_s", ARID_S, {4'h0, v5.id});
            chk("stall_arready_m0", ARREADY_M0, 0);
        end
        @(posedge ACLK); #1;
        ARREADY_S = 1'b1;
        @(negedge ACLK);
        ar_phase(1'b0);
        r_phase(1'b0, v5.nbeats, v5.exp_err);

        // M1 owns the bus; reset mid-DATA drops everything immediately.
        @(posedge ACLK); #1;
        drive_ar(v6);
        @(negedge ACLK);
        ar_phase(1'b1);
        RVALID_S = 1'b1;
        RREADY_M1 = 1'b1;
        @(negedge ACLK);
        chk("pre_rst_rvalid_m1", RVALID_M1, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("async_rst_rvalid_m1", RVALID_M1, 0);
        chk("async_rst_rready_s", RREADY_S, 0);
        chk("async_rst_owner", OWNER, 0);
        chk("async_rst_arvalid_s", ARVALID_S, 0);
        RVALID_S = 1'b0;
        RREADY_M1 = 1'b0;
        @(posedge ACLK); #1;
        ARESETn = 1'b1;
        @(negedge ACLK);

        // Priority was M1 before the reset; after reset M0 must win again.
        both_request(p0, p1);

        chk("scoreboard_empty", 64'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
